// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the unified memory arbiter.
// master: the arbiter itself. slave: the pipeline/memory side facing it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              iren;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dren;
  logic              dwen;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              flush;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  iren, iaddr, dren, dwen, daddr, dstore, flush, mem_rdata, mem_ready,
    output iload, ihit, dload, dhit, mem_ren, mem_wen, mem_addr, mem_wdata,
           busy, timeout_err
  );

  modport slave (
    output iren, iaddr, dren, dwen, daddr, dstore, flush, mem_rdata, mem_ready,
    input  iload, ihit, dload, dhit, mem_ren, mem_wen, mem_addr, mem_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins contention unless it won last time; strobes come only from
// latched state, hits are combinational with mem_ready.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);

  // TIMEOUT=0 disables the abort but still needs a legal counter width
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LIM = LIM[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: last grant went to data
  logic              kill_q, kill_d;       // in-flight fetch was flushed
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;

  logic              ihit, dhit, terr;
  logic [DATA_W-1:0] iload, dload;

  // State and latched access registers; reset abandons any access at once
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

  // Arbitration, completion, flush-kill and timeout
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    terr     = 1'b0;
    iload    = '0;
    dload    = '0;

    case (state_q)
      IDLE: begin
        // data wins contention unless it was served last
        if ((bus.dren | bus.dwen) && (!bus.iren || !last_d_q)) begin
          state_d  = DACC;
          addr_d   = bus.daddr;
          wdata_d  = bus.dstore;
          wr_d     = bus.dwen;
          last_d_d = 1'b1;
          cnt_d    = '0;
          kill_d   = 1'b0;
        end else if (bus.iren) begin
          state_d  = IACC;
          addr_d   = bus.iaddr;
          wdata_d  = '0;
          wr_d     = 1'b0;
          last_d_d = 1'b0;
          cnt_d    = '0;
          kill_d   = 1'b0;
        end
      end
      IACC: begin
        // memory cannot cancel, so a flush only suppresses the hit
        if (bus.flush) kill_d = 1'b1;
        if (bus.mem_ready) begin
          ihit    = !kill_q && !bus.flush;
          iload   = ihit ? bus.mem_rdata : '0;
          state_d = IDLE;
        end
      end
      DACC: begin
        if (bus.mem_ready) begin
          dhit    = 1'b1;
          dload   = wr_q ? '0 : bus.mem_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // ready on the limit cycle counts as completion, not timeout
    if (state_q != IDLE && !bus.mem_ready) begin
      if (TIMEOUT > 0 && cnt_q == CNT_LIM) begin
        state_d = IDLE;
        terr    = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign bus.mem_ren     = (state_q == IACC) || (state_q == DACC && !wr_q);
  assign bus.mem_wen     = (state_q == DACC) && wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = terr;
  assign bus.ihit        = ihit;
  assign bus.iload       = iload;
  assign bus.dhit        = dhit;
  assign bus.dload       = dload;

endmodule
